// File: rtl/aes_inv_mix_column_iter.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_mix_column_iter
// Description : Iterative InvMixColumns for the AES decrypt datapath.
//               Accepts a 128-bit state over valid/ready, transforms
//               COLS_PER_CYCLE columns per BUSY cycle and holds the result
//               until downstream accepts it. A bypass input passes the state
//               through unchanged for the final decrypt round.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_mix_column_iter #(
    // Columns transformed per BUSY cycle; legal values 1, 2, 4
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic [127:0] state_i,
    input  logic         valid_i,
    input  logic         bypass_i,
    output logic         ready_o,
    output logic [127:0] state_o,
    output logic         valid_o,
    input  logic         ready_i
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    // Column counter step; for 4 columns per cycle this truncates to 0,
    // so the single BUSY cycle always starts at and wraps back to column 0.
    localparam logic [1:0] c_step = 2'(COLS_PER_CYCLE);

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse-mix one column; byte 0 (row 0) sits in the top bits
    function automatic logic [31:0] inv_mix(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
            m9[r] = x8[r] ^ a[r];
            mb[r] = x8[r] ^ x2[r] ^ a[r];
            md[r] = x8[r] ^ x4[r] ^ a[r];
            me[r] = x8[r] ^ x4[r] ^ x2[r];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                me[1] ^ mb[2] ^ md[3] ^ m9[0],
                me[2] ^ mb[3] ^ md[0] ^ m9[1],
                me[3] ^ mb[0] ^ md[1] ^ m9[2]};
    endfunction

    logic [1:0]   r_state;
    logic [127:0] r_work;
    logic [1:0]   r_col_cnt;

    logic         w_accept;
    logic         w_last;
    logic [127:0] w_work_nxt;
    logic [31:0]  w_cols     [4];
    logic [31:0]  w_cols_nxt [4];
    logic [1:0]   w_slot_idx [COLS_PER_CYCLE];
    logic [31:0]  w_slot_mix [COLS_PER_CYCLE];

    // Split the working state into its four columns
    genvar c;
    generate
        for (c = 0; c < 4; c++) begin : g_col
            assign w_cols[c] = r_work[127-32*c -: 32];
        end
    endgenerate

    // One mixer per column slot processed this cycle
    genvar k;
    generate
        for (k = 0; k < COLS_PER_CYCLE; k++) begin : g_slot
            assign w_slot_idx[k] = r_col_cnt + 2'(k);
            assign w_slot_mix[k] = inv_mix(w_cols[w_slot_idx[k]]);
        end
    endgenerate

    // Merge the freshly mixed columns back into the working state
    always_comb begin
        w_cols_nxt = w_cols;
        for (int s = 0; s < COLS_PER_CYCLE; s++) begin
            w_cols_nxt[w_slot_idx[s]] = w_slot_mix[s];
        end
        w_work_nxt = {w_cols_nxt[0], w_cols_nxt[1], w_cols_nxt[2], w_cols_nxt[3]};
    end

    assign w_last   = (2'(r_col_cnt + c_step) == 2'd0);
    assign ready_o  = (r_state == c_idle) | ((r_state == c_done) & ready_i);
    assign w_accept = valid_i & ready_o;
    assign valid_o  = (r_state == c_done);
    assign state_o  = r_work;

    // Control FSM plus working state and column counter
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_idle;
            r_work    <= 128'd0;
            r_col_cnt <= 2'd0;
        end else if (w_accept) begin
            r_work    <= state_i;
            r_col_cnt <= 2'd0;
            r_state   <= bypass_i ? c_done : c_busy;
        end else begin
            case (r_state)
                c_busy: begin
                    r_work    <= w_work_nxt;
                    r_col_cnt <= r_col_cnt + c_step;
                    if (w_last) begin
                        r_state <= c_done;
                    end
                end
                c_done: begin
                    if (ready_i) begin
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_mix_column_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_inv_mix_column_iter
// Description : Directed bench for aes_inv_mix_column_iter, plus a random
//               MixColumns -> InvMixColumns round trip for 1, 2 and 4
//               columns per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_inv_mix_column_iter;

    localparam logic [127:0] c_v1 = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] c_r1 = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] c_v2 = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] c_v3 = 128'h4d7ebdf8_4d7ebdf8_4d7ebdf8_4d7ebdf8;
    localparam logic [127:0] c_r3 = 128'h2d26314c_2d26314c_2d26314c_2d26314c;

    logic         clk_i = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] state_i = '0;
    logic         valid_i = 1'b0;
    logic         bypass_i = 1'b0;
    logic         ready_i = 1'b1;
    logic         ready_o;
    logic [127:0] state_o;
    logic         valid_o;

    logic [127:0] rt_state = '0;
    logic         rt_valid = 1'b0;
    logic         rt_bypass = 1'b0;
    logic         rt_ready = 1'b1;
    logic         ready_o2, valid_o2, ready_o4, valid_o4;
    logic [127:0] state_o2, state_o4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    aes_inv_mix_column_iter #(.COLS_PER_CYCLE(1)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .state_i(state_i), .valid_i(valid_i),
        .bypass_i(bypass_i), .ready_o(ready_o), .state_o(state_o),
        .valid_o(valid_o), .ready_i(ready_i)
    );

    aes_inv_mix_column_iter #(.COLS_PER_CYCLE(2)) dut2 (
        .clk_i(clk_i), .rst_n(rst_n), .state_i(rt_state), .valid_i(rt_valid),
        .bypass_i(rt_bypass), .ready_o(ready_o2), .state_o(state_o2),
        .valid_o(valid_o2), .ready_i(rt_ready)
    );

    aes_inv_mix_column_iter #(.COLS_PER_CYCLE(4)) dut4 (
        .clk_i(clk_i), .rst_n(rst_n), .state_i(rt_state), .valid_i(rt_valid),
        .bypass_i(rt_bypass), .ready_o(ready_o4), .state_o(state_o4),
        .valid_o(valid_o4), .ready_i(rt_ready)
    );

    // Forward (encrypt) MixColumns model used to build round-trip stimulus
    function automatic logic [7:0] m2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
            o[103-32*c -: 8] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
        end
        return o;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o);
        end
        n_checks++;
        if (state_o !== 128'd0) begin
            n_fail++; $display("FAIL reset_state: got %h want 0", state_o);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", ready_o);
        end
    endtask

    task automatic test_fips();
        state_i = c_v1; bypass_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL fips_busy[%0d]: valid %b ready %b want 0 0", i, valid_o, ready_o);
            end
            tick();
        end
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL fips_early: valid %b want 0", valid_o);
        end
        tick();
        n_checks++;
        if (valid_o !== 1'b1 || state_o !== c_r1) begin
            n_fail++; $display("FAIL fips_result: valid %b state %h want 1 %h", valid_o, state_o, c_r1);
        end
        tick();
        n_checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            n_fail++; $display("FAIL fips_idle: valid %b ready %b want 0 1", valid_o, ready_o);
        end
    endtask

    task automatic test_bypass();
        state_i = c_v2; bypass_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1;
        tick();
        valid_i = 1'b0; bypass_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b1 || state_o !== c_v2) begin
            n_fail++; $display("FAIL bypass: valid %b state %h want 1 %h", valid_o, state_o, c_v2);
        end
        tick();
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL bypass_idle: valid %b want 0", valid_o);
        end
    endtask

    task automatic test_backpressure();
        state_i = c_v1; bypass_i = 1'b0; valid_i = 1'b1; ready_i = 1'b0;
        tick();
        valid_i = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (valid_o !== 1'b1 || state_o !== c_r1 || ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: valid %b ready %b state %h want 1 0 %h",
                         i, valid_o, ready_o, state_o, c_r1);
            end
            tick();
        end
        ready_i = 1'b1;
        #1;
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_ready_comb: got %b want 1", ready_o);
        end
        tick();
        n_checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: valid %b ready %b want 0 1", valid_o, ready_o);
        end
    endtask

    task automatic test_back_to_back();
        state_i = c_v1; bypass_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1;
        tick();
        state_i = c_v3;
        repeat (4) tick();
        n_checks++;
        if (valid_o !== 1'b1 || state_o !== c_r1 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: valid %b ready %b state %h want 1 1 %h",
                     valid_o, ready_o, state_o, c_r1);
        end
        tick();
        valid_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
            n_fail++; $display("FAIL b2b_no_bubble: valid %b ready %b want 0 0", valid_o, ready_o);
        end
        repeat (4) tick();
        n_checks++;
        if (valid_o !== 1'b1 || state_o !== c_r3) begin
            n_fail++; $display("FAIL b2b_second: valid %b state %h want 1 %h", valid_o, state_o, c_r3);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        state_i = c_v1; bypass_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (valid_o !== 1'b0 || state_o !== 128'd0) begin
            n_fail++; $display("FAIL midop_reset: valid %b state %h want 0 0", valid_o, state_o);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            n_fail++; $display("FAIL midop_release: ready %b valid %b want 1 0", ready_o, valid_o);
        end
        repeat (5) begin
            tick();
            n_checks++;
            if (valid_o !== 1'b0) begin
                n_fail++; $display("FAIL midop_spurious_valid: got %b want 0", valid_o);
            end
        end
        state_i = c_v3; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (valid_o !== 1'b1 || state_o !== c_r3) begin
            n_fail++; $display("FAIL midop_next: valid %b state %h want 1 %h", valid_o, state_o, c_r3);
        end
        tick();
    endtask

    task automatic test_roundtrip();
        logic [127:0] plain;
        int lat1, lat2, lat4;
        logic [127:0] out1, out2, out4;
        for (int n = 0; n < 1000; n++) begin
            plain = {$urandom(), $urandom(), $urandom(), $urandom()};
            state_i = mix_columns(plain); rt_state = state_i;
            bypass_i = 1'b0; ready_i = 1'b1; rt_ready = 1'b1;
            valid_i = 1'b1; rt_valid = 1'b1;
            tick();
            valid_i = 1'b0; rt_valid = 1'b0;
            lat1 = 0; lat2 = 0; lat4 = 0;
            out1 = '0; out2 = '0; out4 = '0;
            for (int k = 1; k <= 6; k++) begin
                tick();
                if (lat1 == 0 && valid_o)  begin lat1 = k; out1 = state_o;  end
                if (lat2 == 0 && valid_o2) begin lat2 = k; out2 = state_o2; end
                if (lat4 == 0 && valid_o4) begin lat4 = k; out4 = state_o4; end
            end
            n_checks++;
            if (out1 !== plain) begin
                n_fail++; $display("FAIL rt1_data[%0d]: got %h want %h", n, out1, plain);
            end
            n_checks++;
            if (lat1 != 4) begin
                n_fail++; $display("FAIL rt1_latency[%0d]: got %0d want 4", n, lat1);
            end
            n_checks++;
            if (out2 !== plain) begin
                n_fail++; $display("FAIL rt2_data[%0d]: got %h want %h", n, out2, plain);
            end
            n_checks++;
            if (lat2 != 2) begin
                n_fail++; $display("FAIL rt2_latency[%0d]: got %0d want 2", n, lat2);
            end
            n_checks++;
            if (out4 !== plain) begin
                n_fail++; $display("FAIL rt4_data[%0d]: got %h want %h", n, out4, plain);
            end
            n_checks++;
            if (lat4 != 1) begin
                n_fail++; $display("FAIL rt4_latency[%0d]: got %0d want 1", n, lat4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_bypass();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        test_roundtrip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
